// File: rtl/bcd3_7seg_scan_if.sv
// Display-stage bus for bcd3_7seg_scan: BCD load side plus the multiplexed 7-seg outputs.
interface bcd3_7seg_scan_if;
    logic       load;
    logic [3:0] bcd_u;
    logic [3:0] bcd_t;
    logic [3:0] bcd_h;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;

    modport master (output load, bcd_u, bcd_t, bcd_h, input seg, an, frame_tick);
    modport slave  (input load, bcd_u, bcd_t, bcd_h, output seg, an, frame_tick);
endinterface

// File: rtl/bcd3_7seg_scan.sv
// 3-digit BCD snapshot, time-multiplexed onto one 7-seg bus with blanking gaps.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module bcd3_7seg_scan #(
    parameter int SCAN_DIV  = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    bcd3_7seg_scan_if.slave   bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAT  = CW'(BLANK_CYC);

    localparam logic [1:0] DIG_U = 2'd0;
    localparam logic [1:0] DIG_T = 2'd1;
    localparam logic [1:0] DIG_H = 2'd2;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    snap_u, snap_t, snap_h;
    logic [3:0]    code_q;
    logic          zb_q;
    logic [6:0]    seg_q;
    logic [2:0]    an_q;
    logic          tick_q;

    logic [3:0]    eff_u, eff_t, eff_h;
    logic [3:0]    sel_code, cur_code;
    logic          sel_zb, cur_zb;
    logic          lit;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Bypass: a load on the latch edge is seen by the digit being latched.
    always_comb begin
        eff_u    = bus.load ? bus.bcd_u : snap_u;
        eff_t    = bus.load ? bus.bcd_t : snap_t;
        eff_h    = bus.load ? bus.bcd_h : snap_h;
        sel_code = 4'd0;
        sel_zb   = 1'b0;
        case (idx)
            DIG_U: sel_code = eff_u;
            DIG_T: begin
                sel_code = eff_t;
`ifdef SEG7_LZB_EN
                sel_zb   = (eff_h == 4'd0) && (eff_t == 4'd0);
`endif
            end
            DIG_H: begin
                sel_code = eff_h;
`ifdef SEG7_LZB_EN
                sel_zb   = (eff_h == 4'd0);
`endif
            end
            default: sel_code = 4'd0;
        endcase
        cur_code = (cnt == CNT_LAT) ? sel_code : code_q;
        cur_zb   = (cnt == CNT_LAT) ? sel_zb   : zb_q;
        lit      = (idx != 2'd3) && (cnt >= CNT_LAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= DIG_U;
            snap_u <= 4'd0;
            snap_t <= 4'd0;
            snap_h <= 4'd0;
            code_q <= 4'd0;
            zb_q   <= 1'b0;
            seg_q  <= 7'h00;
            an_q   <= 3'b111;
            tick_q <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == DIG_U) ? DIG_T : (idx == DIG_T) ? DIG_H : DIG_U;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (bus.load) begin
                snap_u <= bus.bcd_u;
                snap_t <= bus.bcd_t;
                snap_h <= bus.bcd_h;
            end
            if (cnt == CNT_LAT) begin
                code_q <= sel_code;
                zb_q   <= sel_zb;
            end
            if (lit) begin
                an_q  <= ~(3'b001 << idx);
                seg_q <= cur_zb ? 7'h00 : decode(cur_code);
            end else begin
                an_q  <= 3'b111;
                seg_q <= 7'h00;
            end
            tick_q <= (idx == DIG_H) && (cnt == CNT_LAST);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule
